// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_responder
// Purpose  : Line-granular backing-store RAM model with fixed-latency
//            read-fill and write-back handshake, one transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
    parameter int ADDR_BITS   = 32,
    parameter int LINE_BITS   = 128,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4,
    parameter     INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [LINE_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [LINE_BITS-1:0] wr_line,
    output logic                 wr_done,
    output logic                 busy
);

    localparam int       c_OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int       c_IDX_BITS    = $clog2(DEPTH_LINES);
    localparam logic [7:0] c_LOAD      = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [7:0]              r_count;
    logic [c_IDX_BITS-1:0]   r_idx;
    logic [LINE_BITS-1:0]    r_wrLine;
    logic                    r_opWrite;
    logic                    w_accept;
    logic                    w_unused;
    logic [LINE_BITS-1:0]    r_mem [DEPTH_LINES];

    // Offset and alias bits of the addresses are deliberately dropped.
    assign w_unused = ^{rd_addr, wr_addr};
    assign w_accept = (r_state == IDLE) && (wr_req || rd_req);
    assign busy     = (r_state != IDLE);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (wr_req || rd_req) w_stateNext = ACCESS;
            ACCESS:  if (r_count == 8'd0) w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= 8'd0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            rd_data  <= '0;
        end else begin
            r_state  <= w_stateNext;
            rd_valid <= (r_state == DONE) && !r_opWrite;
            wr_done  <= (r_state == DONE) && r_opWrite;
            if ((r_state == DONE) && !r_opWrite) begin
                rd_data <= r_mem[r_idx];
            end
            if (w_accept) begin
                r_count <= c_LOAD;
            end else if ((r_state == ACCESS) && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end
        end
    end

    // Write wins when both requests arrive together.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opWrite <= wr_req;
            if (wr_req) begin
                r_idx    <= wr_addr[c_OFFSET_BITS +: c_IDX_BITS];
                r_wrLine <= wr_line;
            end else begin
                r_idx    <= rd_addr[c_OFFSET_BITS +: c_IDX_BITS];
            end
        end
    end

    // Array holds its contents across reset; an aborted write never lands.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == DONE) && r_opWrite) begin
            r_mem[r_idx] <= r_wrLine;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_mem_responder
// Purpose  : Scoreboard bench for line_mem_responder at LATENCY 4 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

    logic         clk;
    logic         rst     [2];
    logic         rdReq   [2];
    logic         wrReq   [2];
    logic         rdValid [2];
    logic         wrDone  [2];
    logic         busy    [2];
    logic [31:0]  rdAddr  [2];
    logic [31:0]  wrAddr  [2];
    logic [127:0] wrLine  [2];
    logic [127:0] rdData  [2];

    int cyc;
    int nChecks;
    int nPass;

    typedef struct {
        bit           isWrite;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [127:0] model1 [16];

    localparam logic [127:0] c_LINE1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] c_A5    = {16{8'hA5}};
    localparam logic [127:0] c_L     = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
    localparam logic [127:0] c_P     = 128'h50505050_60606060_70707070_80808080;
    localparam logic [127:0] c_X     = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    line_mem_responder #(.LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .rd_req(rdReq[0]), .rd_addr(rdAddr[0]), .rd_data(rdData[0]), .rd_valid(rdValid[0]),
        .wr_req(wrReq[0]), .wr_addr(wrAddr[0]), .wr_line(wrLine[0]), .wr_done(wrDone[0]),
        .busy(busy[0])
    );

    line_mem_responder #(.LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .rd_req(rdReq[1]), .rd_addr(rdAddr[1]), .rd_data(rdData[1]), .rd_valid(rdValid[1]),
        .wr_req(wrReq[1]), .wr_addr(wrAddr[1]), .wr_line(wrLine[1]), .wr_done(wrDone[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic pushExp(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic onPulse(input int id);
        exp_t e;
        bit   empty;
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            nChecks++;
            $display("FAIL unexpected_pulse dut%0d: rd_valid=%b wr_done=%b with no pending transaction (cycle %0d)",
                     id, rdValid[id], wrDone[id], cyc);
        end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("pulse_kind dut%0d", id), 128'({wrDone[id], rdValid[id]}),
                e.isWrite ? 128'd2 : 128'd1);
            chk($sformatf("pulse_cycle dut%0d", id), 128'(cyc), 128'(e.cyc));
            if (!e.isWrite) chk($sformatf("rd_data dut%0d", id), rdData[id], e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rdValid[0] || wrDone[0]) onPulse(0);
        if (rdValid[1] || wrDone[1]) onPulse(1);
    end

    task automatic waitIdle(input int id);
        for (int k = 0; k < 100 && busy[id] !== 1'b0; k++) begin
            @(posedge clk); #1;
        end
        chk("idle_before_req", 128'(busy[id]), 128'd0);
    endtask

    task automatic waitPulse(input int id, input bit isWr, input bit checkBusy);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 0 && checkBusy) chk("busy_after_accept", 128'(busy[id]), 128'd1);
            seen = isWr ? wrDone[id] : rdValid[id];
        end
        chk("pulse_seen", 128'(seen), 128'd1);
    endtask

    task automatic issue(input int id, input bit isWr, input logic [31:0] addr,
                         input logic [127:0] line, input logic [127:0] expRd);
        exp_t e;
        int   lat;
        lat = (id == 0) ? 4 : 2;
        waitIdle(id);
        if (isWr) begin
            wrAddr[id] = addr; wrLine[id] = line; wrReq[id] = 1'b1;
        end else begin
            rdAddr[id] = addr; rdReq[id] = 1'b1;
        end
        e.isWrite = isWr;
        e.data    = isWr ? line : expRd;
        e.cyc     = cyc + 1 + lat;
        pushExp(id, e);
        waitPulse(id, isWr, 1'b1);
        chk("busy_at_pulse", 128'(busy[id]), 128'd0);
        wrReq[id] = 1'b0;
        rdReq[id] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        nChecks = 0;
        nPass   = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rdReq[d] = 1'b0; wrReq[d] = 1'b0;
            rdAddr[d] = '0; wrAddr[d] = '0; wrLine[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_valid", 128'(rdValid[0]), 128'd0);
        chk("reset wr_done",  128'(wrDone[0]),  128'd0);
        chk("reset busy",     128'(busy[0]),    128'd0);
        chk("reset rd_data",  rdData[0],        128'd0);
        chk("reset busy dut1", 128'(busy[1]),   128'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk); #1;

        // Basic write then read of the same line
        issue(0, 1'b1, 32'h0000_1000, c_LINE1, '0);
        issue(0, 1'b0, 32'h0000_1000, '0, c_LINE1);

        // Simultaneous requests: write first, then the pending read
        waitIdle(0);
        wrAddr[0] = 32'h0000_1000; wrLine[0] = c_A5; wrReq[0] = 1'b1;
        rdAddr[0] = 32'h0000_1000; rdReq[0] = 1'b1;
        e.isWrite = 1'b1; e.data = c_A5; e.cyc = cyc + 5;  pushExp(0, e);
        e.isWrite = 1'b0; e.data = c_A5; e.cyc = cyc + 10; pushExp(0, e);
        waitPulse(0, 1'b1, 1'b1);
        wrReq[0] = 1'b0;
        waitPulse(0, 1'b0, 1'b1);
        rdReq[0] = 1'b0;

        // Aliasing and ignored offset bits
        issue(0, 1'b1, 32'h0000_0000, c_L, '0);
        issue(0, 1'b0, 32'h0000_4000, '0, c_L);
        issue(0, 1'b0, 32'h0000_000C, '0, c_L);

        // Held request re-accepted only after DONE; address change during ACCESS ignored
        waitIdle(0);
        rdAddr[0] = 32'h0000_1000; rdReq[0] = 1'b1;
        e.isWrite = 1'b0; e.data = c_A5; e.cyc = cyc + 5;  pushExp(0, e);
        e.isWrite = 1'b0; e.data = c_L;  e.cyc = cyc + 10; pushExp(0, e);
        @(posedge clk); #1;
        rdAddr[0] = 32'h0000_000C;
        waitPulse(0, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rdReq[0] = 1'b0;
        waitPulse(0, 1'b0, 1'b0);

        // Reset during a write aborts it and leaves the array untouched
        issue(0, 1'b1, 32'h0000_2000, c_P, '0);
        issue(0, 1'b0, 32'h0000_2000, '0, c_P);
        waitIdle(0);
        wrAddr[0] = 32'h0000_2000; wrLine[0] = c_X; wrReq[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        wrReq[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid rd_valid", 128'(rdValid[0]), 128'd0);
        chk("rst_mid wr_done",  128'(wrDone[0]),  128'd0);
        chk("rst_mid busy",     128'(busy[0]),    128'd0);
        chk("rst_mid rd_data",  rdData[0],        128'd0);
        rst[0] = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        issue(0, 1'b0, 32'h0000_2000, '0, c_P);

        // LATENCY=2 back-to-back sweep against a reference model
        for (int i = 0; i < 16; i++) begin
            model1[i] = {4{32'hC0DE_0000 + 32'(i)}};
            issue(1, 1'b1, 32'(i * 16 + (i % 16)), model1[i], '0);
            issue(1, 1'b0, 32'h0001_0000 + 32'((i / 2) * 16), '0, model1[i / 2]);
        end

        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty dut0", 128'(q0.size()), 128'd0);
        chk("scoreboard_empty dut1", 128'(q1.size()), 128'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
